// File: rtl/dmem_mmio.sv
// Data-side memory subsystem: byte-lane data RAM plus an MMIO block holding a
// UART transmitter with TX FIFO, a free-running cycle timer and a halt register.
module dmem_mmio #(
   parameter int XLEN      = 32,
   parameter int RAM_WORDS = 1024,
   parameter int TX_DEPTH  = 8,
   parameter int CLK_DIV   = 16
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            adr_v_i,
   input  logic [XLEN-1:0] adr_i,
   input  logic            is_store_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [2:0]      access_size_i,
   output logic [XLEN-1:0] load_data_o,
   output logic            uart_tx_o,
   output logic            halt_o,
   output logic [7:0]      halt_code_o,
   output logic            misalign_o
);

   localparam int AW    = $clog2(RAM_WORDS);
   localparam int PW    = $clog2(TX_DEPTH);
   localparam int DIV_W = $clog2(CLK_DIV);
   localparam int LANES = XLEN / 8;

   localparam logic [1:0] REG_TX_DATA   = 2'd0;
   localparam logic [1:0] REG_TX_STATUS = 2'd1;
   localparam logic [1:0] REG_MTIME     = 2'd2;
   localparam logic [1:0] REG_HALT      = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
   } tx_state_t;

   // ---------------------------------------------------------------- decode
   logic            size_ok;
   logic            sel_ram;
   logic            sel_mmio;
   logic            acc_bad;
   logic            acc_ok;
   logic            ram_wr;
   logic            mmio_wr;
   logic [1:0]      reg_sel;
   logic [AW-1:0]   ram_idx;

   always_comb begin
      size_ok = 1'b0;
      case (access_size_i)
         3'd0:    size_ok = 1'b1;
         3'd1:    size_ok = ~adr_i[0];
         3'd2:    size_ok = (adr_i[1:0] == 2'b00);
         default: size_ok = 1'b0;
      endcase
   end

   assign sel_ram  = (adr_i[31:28] == 4'h0);
   assign sel_mmio = (adr_i[31:4] == 28'h1000000);
   // MMIO registers only accept aligned word accesses; anything narrower is misaligned
   assign acc_bad  = ~size_ok | (sel_mmio & (access_size_i != 3'd2));
   assign acc_ok   = adr_v_i & ~acc_bad;
   assign ram_wr   = acc_ok & is_store_i & sel_ram;
   assign mmio_wr  = acc_ok & is_store_i & sel_mmio;
   assign reg_sel  = adr_i[3:2];
   assign ram_idx  = adr_i[AW+1:2];

   // ---------------------------------------------------------------- data RAM
   logic [LANES-1:0] lane_we;
   logic [XLEN-1:0]  wr_data;
   logic [XLEN-1:0]  ram_word;
   logic [XLEN-1:0]  ram_shift;

   always_comb begin
      lane_we = '0;
      wr_data = store_data_i;
      if (ram_wr) begin
         case (access_size_i)
            3'd0: begin
               lane_we[adr_i[1:0]] = 1'b1;
               wr_data = {LANES{store_data_i[7:0]}};
            end
            3'd1: begin
               lane_we = adr_i[1] ? 4'b1100 : 4'b0011;
               wr_data = {(LANES/2){store_data_i[15:0]}};
            end
            default: lane_we = '1;
         endcase
      end
   end

   // One narrow array per byte lane so partial stores need no read-modify-write
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [7:0] mem [RAM_WORDS];

      always_ff @(posedge clk) begin
         if (lane_we[gi]) begin
            mem[ram_idx] <= wr_data[gi*8 +: 8];
         end
      end

      assign ram_word[gi*8 +: 8] = mem[ram_idx];
   end

   assign ram_shift = ram_word >> {adr_i[1:0], 3'b000};

   // ---------------------------------------------------------------- TX FIFO
   logic [7:0]    fifo_mem [TX_DEPTH];
   logic [PW-1:0] wr_ptr_reg;
   logic [PW-1:0] rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          ovf_reg;
   logic          fifo_full;
   logic          fifo_empty;
   logic          tx_store;
   logic          push;
   logic          pop;

   tx_state_t     state_reg, state_next;
   logic [DIV_W-1:0] div_reg, div_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          line_reg, line_next;
   logic          div_last;

   assign fifo_full  = (count_reg == (PW+1)'(TX_DEPTH));
   assign fifo_empty = (count_reg == '0);
   assign pop        = (state_reg == ST_IDLE) & ~fifo_empty;
   assign tx_store   = mmio_wr & (reg_sel == REG_TX_DATA);
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands
   assign push       = tx_store & (~fifo_full | pop);

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_reg] <= store_data_i[7:0];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         if (push && !pop) begin
            count_reg <= count_reg + (PW+1)'(1);
         end else if (pop && !push) begin
            count_reg <= count_reg - (PW+1)'(1);
         end
         if (tx_store && fifo_full && !pop) begin
            ovf_reg <= 1'b1;
         end else if (mmio_wr && (reg_sel == REG_TX_STATUS)) begin
            ovf_reg <= 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------- serializer
   assign div_last = (div_reg == DIV_W'(CLK_DIV - 1));

   always_comb begin
      state_next = state_reg;
      div_next   = div_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      line_next  = 1'b1;
      case (state_reg)
         ST_IDLE: begin
            if (!fifo_empty) begin
               shift_next = fifo_mem[rd_ptr_reg];
               div_next   = '0;
               state_next = ST_START;
            end
         end
         ST_START: begin
            if (div_last) begin
               div_next   = '0;
               bit_next   = 3'd0;
               state_next = ST_DATA;
            end else begin
               div_next = div_reg + DIV_W'(1);
            end
         end
         ST_DATA: begin
            if (div_last) begin
               div_next   = '0;
               shift_next = shift_reg >> 1;
               bit_next   = bit_reg + 3'd1;
               if (bit_reg == 3'd7) begin
                  state_next = ST_STOP;
               end
            end else begin
               div_next = div_reg + DIV_W'(1);
            end
         end
         ST_STOP: begin
            if (div_last) begin
               div_next   = '0;
               state_next = ST_IDLE;
            end else begin
               div_next = div_reg + DIV_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
      // The line is registered from the next state so it changes with the state
      case (state_next)
         ST_START: line_next = 1'b0;
         ST_DATA:  line_next = shift_next[0];
         default:  line_next = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
         div_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         line_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         div_reg   <= div_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         line_reg  <= line_next;
      end
   end

   assign uart_tx_o = line_reg;

   // ---------------------------------------------------------------- timer, halt, flags
   logic [XLEN-1:0] mtime_reg;
   logic            halt_reg;
   logic [7:0]      halt_code_reg;
   logic            misalign_reg;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mtime_reg     <= '0;
         halt_reg      <= 1'b0;
         halt_code_reg <= '0;
         misalign_reg  <= 1'b0;
      end else begin
         if (mmio_wr && (reg_sel == REG_MTIME)) begin
            mtime_reg <= store_data_i;
         end else begin
            mtime_reg <= mtime_reg + XLEN'(1);
         end
         if (mmio_wr && (reg_sel == REG_HALT) && !halt_reg) begin
            halt_reg      <= 1'b1;
            halt_code_reg <= store_data_i[7:0];
         end
         if (adr_v_i && acc_bad) begin
            misalign_reg <= 1'b1;
         end
      end
   end

   assign halt_o      = halt_reg;
   assign halt_code_o = halt_code_reg;
   assign misalign_o  = misalign_reg;

   // ---------------------------------------------------------------- load path
   always_comb begin
      load_data_o = '0;
      if (acc_ok && !is_store_i) begin
         if (sel_ram) begin
            case (access_size_i)
               3'd0:    load_data_o = {24'b0, ram_shift[7:0]};
               3'd1:    load_data_o = {16'b0, ram_shift[15:0]};
               default: load_data_o = ram_shift;
            endcase
         end else if (sel_mmio) begin
            case (reg_sel)
               REG_TX_STATUS: load_data_o = {28'b0, ovf_reg, (state_reg != ST_IDLE),
                                             fifo_empty, fifo_full} & 32'h0000_000F;
               REG_MTIME:     load_data_o = mtime_reg;
               REG_HALT:      load_data_o = {23'b0, halt_reg, halt_code_reg};
               default:       load_data_o = '0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_dmem_mmio.sv
// Bench for dmem_mmio: directed literal checks followed by random traffic,
// all outputs compared every cycle against a byte-level behavioural model.
module tb_dmem_mmio;

   localparam int CD    = 4;
   localparam int DEPTH = 8;

   logic        clk;
   logic        reset_n;
   logic        adr_v_i;
   logic [31:0] adr_i;
   logic        is_store_i;
   logic [31:0] store_data_i;
   logic [2:0]  access_size_i;
   logic [31:0] load_data_o;
   logic        uart_tx_o;
   logic        halt_o;
   logic [7:0]  halt_code_o;
   logic        misalign_o;

   dmem_mmio #(.XLEN(32), .RAM_WORDS(1024), .TX_DEPTH(DEPTH), .CLK_DIV(CD)) dut (
      .clk(clk), .reset_n(reset_n), .adr_v_i(adr_v_i), .adr_i(adr_i),
      .is_store_i(is_store_i), .store_data_i(store_data_i),
      .access_size_i(access_size_i), .load_data_o(load_data_o),
      .uart_tx_o(uart_tx_o), .halt_o(halt_o), .halt_code_o(halt_code_o),
      .misalign_o(misalign_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------ model state
   logic [7:0]  mb [4096];   // byte-addressed image of RAM (12 address bits alias)
   logic [7:0]  q [$];       // TX FIFO contents
   bit          m_ok = 0;
   bit          fa;          // a frame is on the line
   int          ft;          // cycles since frame start
   logic [7:0]  fb;
   logic [31:0] m_mtime;
   bit          m_halt, m_ovf, m_mis;
   logic [7:0]  m_code;

   function automatic bit m_bad(input logic [31:0] a, input logic [2:0] sz);
      if (sz > 3'd2) return 1;
      if (sz == 3'd1 && a[0]) return 1;
      if (sz == 3'd2 && a[1:0] != 2'b00) return 1;
      if (a[31:4] == 28'h1000000 && sz != 3'd2) return 1;
      return 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] sz);
      logic [31:0] r;
      logic [11:0] bi;
      r = 0;
      if (m_bad(a, sz)) return 0;
      if (a[31:28] == 4'h0) begin
         for (int i = 0; i < (1 << sz); i++) begin
            bi = a[11:0] + 12'(i);
            r = r | (32'(mb[bi]) << (8 * i));
         end
         return r;
      end
      if (a[31:4] == 28'h1000000) begin
         case (a[3:2])
            2'd1: return {28'b0, m_ovf, fa, (q.size() == 0), (q.size() == DEPTH)};
            2'd2: return m_mtime;
            2'd3: return {23'b0, m_halt, m_code};
            default: return 0;
         endcase
      end
      return 0;
   endfunction

   function automatic logic m_line();
      if (!fa) return 1'b1;
      if (ft < CD) return 1'b0;
      if (ft < 9 * CD) return fb[ft / CD - 1];
      return 1'b1;
   endfunction

   task automatic model_step();
      int pre;
      bit popd;
      logic [31:0] nt;
      logic [11:0] bi;
      if (!reset_n) begin
         q.delete();
         fa = 0; ft = 0; m_mtime = 0; m_halt = 0; m_code = 0; m_ovf = 0; m_mis = 0;
         m_ok = 1;
         return;
      end
      if (!m_ok) return;
      pre  = q.size();
      popd = 0;
      nt   = m_mtime + 1;
      if (adr_v_i && m_bad(adr_i, access_size_i)) m_mis = 1;
      if (fa) begin
         ft++;
         if (ft == 10 * CD) fa = 0;
      end else if (pre > 0) begin
         fb = q.pop_front();
         fa = 1; ft = 0; popd = 1;
      end
      if (adr_v_i && is_store_i && !m_bad(adr_i, access_size_i)) begin
         if (adr_i[31:28] == 4'h0) begin
            for (int i = 0; i < (1 << access_size_i); i++) begin
               bi = adr_i[11:0] + 12'(i);
               mb[bi] = store_data_i[8*i +: 8];
            end
         end else if (adr_i[31:4] == 28'h1000000) begin
            case (adr_i[3:2])
               2'd0: if (pre < DEPTH || popd) q.push_back(store_data_i[7:0]); else m_ovf = 1;
               2'd1: m_ovf = 0;
               2'd2: nt = store_data_i;
               default: if (!m_halt) begin m_halt = 1; m_code = store_data_i[7:0]; end
            endcase
         end
      end
      m_mtime = nt;
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // Every-cycle comparison against the model
   initial forever begin
      @(negedge clk);
      if (m_ok) begin
         chk("uart_tx", 32'(uart_tx_o), 32'(m_line()));
         chk("halt", 32'(halt_o), 32'(m_halt));
         chk("halt_code", 32'(halt_code_o), 32'(m_code));
         chk("misalign", 32'(misalign_o), 32'(m_mis));
         if (adr_v_i && !is_store_i)
            chk("load", load_data_o, m_load(adr_i, access_size_i));
      end
   end

   // ------------------------------------------------------------ stimulus
   task automatic drive(input logic v, input logic [31:0] a, input logic st,
                        input logic [31:0] d, input logic [2:0] sz);
      @(posedge clk);
      #1;
      reset_n = 1'b1; adr_v_i = v; adr_i = a; is_store_i = st;
      store_data_i = d; access_size_i = sz;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset_n = 1'b0; adr_v_i = 1'b0;
      @(negedge clk);
   endtask

   task automatic idle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 3'd2);
   endtask

   localparam logic [31:0] A_TXD = 32'h1000_0000;
   localparam logic [31:0] A_STS = 32'h1000_0004;
   localparam logic [31:0] A_MT  = 32'h1000_0008;
   localparam logic [31:0] A_HLT = 32'h1000_000C;

   initial begin
      logic [9:0] frame;
      logic [31:0] a;
      int r;
      frame = 10'b1010101010;   // line per bit slot for byte 0x55, start first
      reset_n = 1'b0; adr_v_i = 1'b0; adr_i = '0; is_store_i = 1'b0;
      store_data_i = '0; access_size_i = 3'd2;
      do_reset();
      do_reset();
      idle();
      chk("rst_uart", 32'(uart_tx_o), 32'd1);
      chk("rst_halt", 32'(halt_o), 32'd0);
      chk("rst_mis", 32'(misalign_o), 32'd0);

      // RAM byte lanes
      drive(1, 32'h100, 1, 32'h11223344, 3'd2);
      drive(1, 32'h101, 1, 32'h000000AA, 3'd0);
      drive(1, 32'h100, 0, 32'h0, 3'd2);
      chk("lw_lanes", load_data_o, 32'h1122AA44);
      drive(1, 32'h102, 0, 32'h0, 3'd1);
      chk("lh_upper", load_data_o, 32'h00001122);
      drive(1, 32'h0ABC_D100, 0, 32'h0, 3'd0);
      chk("lb_alias", load_data_o, 32'h00000044);

      // Misalignment
      drive(1, 32'h102, 0, 32'h0, 3'd2);
      chk("lw_misal", load_data_o, 32'h0);
      idle();
      chk("misal_flag", 32'(misalign_o), 32'd1);
      drive(1, 32'h101, 1, 32'h0000BEEF, 3'd1);
      drive(1, 32'h100, 0, 32'h0, 3'd2);
      chk("sh_dropped", load_data_o, 32'h1122AA44);

      // MTIME wrap
      do_reset();
      drive(1, A_MT, 1, 32'hFFFF_FFFE, 3'd2);
      idle();
      drive(1, A_MT, 0, 32'h0, 3'd2);
      chk("mtime_n2", load_data_o, 32'hFFFF_FFFF);
      drive(1, A_MT, 0, 32'h0, 3'd2);
      chk("mtime_n3", load_data_o, 32'h0);

      // UART frame of 0x55
      drive(1, A_TXD, 1, 32'h55, 3'd2);
      drive(1, A_STS, 0, 32'h0, 3'd2);
      chk("tx_prepop_line", 32'(uart_tx_o), 32'd1);
      chk("tx_prepop_sts", load_data_o, 32'h0);
      for (int k = 0; k < 10 * CD; k++) begin
         drive(1, A_STS, 0, 32'h0, 3'd2);
         chk("tx_frame_line", 32'(uart_tx_o), 32'(frame[k / CD]));
         chk("tx_frame_busy", load_data_o, 32'h6);
      end
      drive(1, A_STS, 0, 32'h0, 3'd2);
      chk("tx_done_line", 32'(uart_tx_o), 32'd1);
      chk("tx_done_sts", load_data_o, 32'h2);

      // FIFO overflow
      for (int k = 0; k < 10; k++) drive(1, A_TXD, 1, 32'(8'hA0 + k), 3'd2);
      drive(1, A_STS, 0, 32'h0, 3'd2);
      chk("ovf_sts", load_data_o, 32'hD);
      drive(1, A_STS, 1, 32'h0, 3'd2);
      drive(1, A_STS, 0, 32'h0, 3'd2);
      chk("ovf_clr", load_data_o, 32'h5);

      // Halt, then reset mid-frame
      drive(1, A_HLT, 1, 32'h2A, 3'd2);
      drive(1, A_HLT, 0, 32'h0, 3'd2);
      chk("halt_set", 32'(halt_o), 32'd1);
      chk("halt_code", 32'(halt_code_o), 32'h2A);
      chk("halt_rd", load_data_o, 32'h12A);
      drive(1, A_HLT, 1, 32'h01, 3'd2);
      drive(1, A_HLT, 0, 32'h0, 3'd2);
      chk("halt_sticky", load_data_o, 32'h12A);
      do_reset();
      drive(1, A_STS, 0, 32'h0, 3'd2);
      chk("rst_mid_line", 32'(uart_tx_o), 32'd1);
      chk("rst_mid_halt", 32'(halt_o), 32'd0);
      chk("rst_mid_sts", load_data_o, 32'h2);

      // Random traffic
      for (int i = 0; i < 8; i++) drive(1, 32'h100 + 32'(4 * i), 1, $urandom, 3'd2);
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            do_reset();
         end else begin
            r = $urandom_range(0, 99);
            if (r < 50)      a = {4'h0, 16'($urandom), 12'h100 + 12'($urandom_range(0, 31))};
            else if (r < 85) a = A_TXD + 32'($urandom_range(0, 15));
            else             a = {4'($urandom_range(1, 15)), 28'($urandom)};
            drive(($urandom_range(0, 9) != 0), a, 1'($urandom),
                  $urandom,
                  ($urandom_range(0, 15) == 0) ? 3'($urandom_range(3, 7))
                                               : 3'($urandom_range(0, 2)));
         end
      end
      idle();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
